pkt_length_accumulator: RTL and testbench

- Sits directly downstream of the packet snooper's keep-to-byte-count stage.
- Combines the registered per-flit byte count with the snooped beat qualifiers to measure every packet in bytes and flits.
- Emits one length record per packet through a small valid/ready FIFO, and keeps running packet/byte totals and a drop counter for the traffic monitor's register interface.

---
 rtl/pkt_length_accumulator_if.sv | 27 ++
 rtl/pkt_length_accumulator.sv | 158 +++++++++++++++
 tb/tb_pkt_length_accumulator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pkt_length_accumulator_if.sv
// rtl/pkt_length_accumulator_if.sv - length record stream between accumulator FIFO and consumer
interface pkt_length_accumulator_if #(
    parameter int LEN_WIDTH  = 16,
    parameter int FLIT_WIDTH = 12
);
    logic                  rec_valid;
    logic                  rec_ready;
    logic [LEN_WIDTH-1:0]  rec_len;
    logic [FLIT_WIDTH-1:0] rec_flits;
    logic                  rec_sat;

    modport master (
        output rec_valid,
        input  rec_ready,
        output rec_len,
        output rec_flits,
        output rec_sat
    );

    modport slave (
        input  rec_valid,
        output rec_ready,
        input  rec_len,
        input  rec_flits,
        input  rec_sat
    );
endinterface

// File: rtl/pkt_length_accumulator.sv
// rtl/pkt_length_accumulator.sv - per-packet byte/flit length records, running totals and drop counter
module pkt_length_accumulator #(
    parameter int TDATA_WIDTH = 256,
    parameter int LEN_WIDTH   = 16,
    parameter int FLIT_WIDTH  = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int TOTAL_WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   snoop_beat,
    input  logic                   snoop_last,
    input  logic [7:0]             bytes_in_flit,
    input  logic                   stats_clear,
    pkt_length_accumulator_if.master rec,
    output logic [TOTAL_WIDTH-1:0] total_pkts,
    output logic [TOTAL_WIDTH-1:0] total_bytes,
    output logic [15:0]            drop_count
);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int MAX_BYTES = TDATA_WIDTH / 8;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] IN_PKT = 1'b1;

    logic [0:0]            state;
    logic                  beat_d;
    logic                  last_d;
    logic [LEN_WIDTH-1:0]  acc_len;
    logic [FLIT_WIDTH-1:0] acc_flits;
    logic                  sat;

    logic [7:0]            bytes_eff;
    logic [LEN_WIDTH-1:0]  base_len;
    logic [FLIT_WIDTH-1:0] base_flits;
    logic                  base_sat;
    logic [LEN_WIDTH:0]    len_sum;
    logic [LEN_WIDTH-1:0]  next_len;
    logic [FLIT_WIDTH-1:0] next_flits;
    logic                  next_sat;
    logic                  complete;

    logic [LEN_WIDTH-1:0]  len_mem   [FIFO_DEPTH];
    logic [FLIT_WIDTH-1:0] flits_mem [FIFO_DEPTH];
    logic                  sat_mem   [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  pop;
    logic                  push;

    // A keep wider than the snooped bus is impossible on legal traffic; cap it there.
    always_comb begin
        bytes_eff = bytes_in_flit;
        if ({1'b0, bytes_in_flit} > 9'(MAX_BYTES)) begin
            bytes_eff = 8'(MAX_BYTES);
        end
    end

    // A beat seen in IDLE starts from zero, so one adder covers first, middle and last flits.
    always_comb begin
        base_len   = '0;
        base_flits = '0;
        base_sat   = 1'b0;
        if (state == IN_PKT) begin
            base_len   = acc_len;
            base_flits = acc_flits;
            base_sat   = sat;
        end
        len_sum  = {1'b0, base_len} + (LEN_WIDTH+1)'(bytes_eff);
        next_len = len_sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : len_sum[LEN_WIDTH-1:0];
        if (base_flits == {FLIT_WIDTH{1'b1}}) begin
            next_flits = base_flits;
            next_sat   = 1'b1;
        end else begin
            next_flits = base_flits + 1'b1;
            next_sat   = base_sat | len_sum[LEN_WIDTH];
        end
    end

    assign complete = beat_d & last_d;
    assign full     = (count == DEPTH_C);
    assign pop      = rec.rec_valid & rec.rec_ready;
    assign push     = complete & (~full | pop);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            beat_d    <= 1'b0;
            last_d    <= 1'b0;
            state     <= IDLE;
            acc_len   <= '0;
            acc_flits <= '0;
            sat       <= 1'b0;
        end else begin
            beat_d <= snoop_beat;
            last_d <= snoop_last & snoop_beat;
            if (beat_d) begin
                acc_len   <= next_len;
                acc_flits <= next_flits;
                sat       <= next_sat;
                state     <= last_d ? IDLE : IN_PKT;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                len_mem[i]   <= '0;
                flits_mem[i] <= '0;
                sat_mem[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                len_mem[wr_ptr]   <= next_len;
                flits_mem[wr_ptr] <= next_flits;
                sat_mem[wr_ptr]   <= next_sat;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rec.rec_valid = (count != '0);
    assign rec.rec_len   = len_mem[rd_ptr];
    assign rec.rec_flits = flits_mem[rd_ptr];
    assign rec.rec_sat   = sat_mem[rd_ptr];

    // Totals count every completed packet, including ones whose record was dropped.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            total_pkts  <= '0;
            total_bytes <= '0;
            drop_count  <= '0;
        end else if (stats_clear) begin
            total_pkts  <= '0;
            total_bytes <= '0;
            drop_count  <= '0;
        end else if (complete) begin
            total_pkts  <= total_pkts + 1'b1;
            total_bytes <= total_bytes + TOTAL_WIDTH'(next_len);
            if (!push && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pkt_length_accumulator.sv
// tb/tb_pkt_length_accumulator.sv - directed self-checking bench for pkt_length_accumulator
module tb_pkt_length_accumulator;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        snoop_beat = 1'b0;
    logic        snoop_last = 1'b0;
    logic [7:0]  bytes_in_flit = 8'd0;
    logic        stats_clear = 1'b0;
    logic [47:0] total_pkts;
    logic [47:0] total_bytes;
    logic [15:0] drop_count;
    logic [7:0]  pend_bytes = 8'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pkt_length_accumulator_if #(.LEN_WIDTH(16), .FLIT_WIDTH(12)) rec_bus ();

    pkt_length_accumulator #(
        .TDATA_WIDTH(256), .LEN_WIDTH(16), .FLIT_WIDTH(12),
        .FIFO_DEPTH(4), .TOTAL_WIDTH(48)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .snoop_beat(snoop_beat),
        .snoop_last(snoop_last),
        .bytes_in_flit(bytes_in_flit),
        .stats_clear(stats_clear),
        .rec(rec_bus.master),
        .total_pkts(total_pkts),
        .total_bytes(total_bytes),
        .drop_count(drop_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: byte count of the previous beat appears alongside this cycle's qualifiers.
    task automatic step(input logic beat, input logic last, input logic [7:0] bytes);
        snoop_beat    = beat;
        snoop_last    = last;
        bytes_in_flit = pend_bytes;
        pend_bytes    = beat ? bytes : 8'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic pop_one();
        rec_bus.rec_ready = 1'b1;
        idle(1);
        rec_bus.rec_ready = 1'b0;
    endtask

    initial begin
        rec_bus.rec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(rec_bus.rec_valid), 64'd0);
        check("rst_len", 64'(rec_bus.rec_len), 64'd0);
        check("rst_flits", 64'(rec_bus.rec_flits), 64'd0);
        check("rst_sat", 64'(rec_bus.rec_sat), 64'd0);
        check("rst_pkts", 64'(total_pkts), 64'd0);
        check("rst_bytes", 64'(total_bytes), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        aresetn = 1'b1;
        idle(1);

        // 3-flit packet 32,32,5
        step(1, 0, 8'd32);
        step(1, 0, 8'd32);
        step(1, 1, 8'd5);
        idle(1);
        check("p3_valid", 64'(rec_bus.rec_valid), 64'd1);
        check("p3_len", 64'(rec_bus.rec_len), 64'd69);
        check("p3_flits", 64'(rec_bus.rec_flits), 64'd3);
        check("p3_sat", 64'(rec_bus.rec_sat), 64'd0);
        check("p3_pkts", 64'(total_pkts), 64'd1);
        check("p3_bytes", 64'(total_bytes), 64'd69);
        pop_one();
        check("p3_popped", 64'(rec_bus.rec_valid), 64'd0);

        // single-flit packet followed immediately by a 2-flit packet
        step(1, 1, 8'd1);
        step(1, 0, 8'd32);
        check("s1_len", 64'(rec_bus.rec_len), 64'd1);
        check("s1_flits", 64'(rec_bus.rec_flits), 64'd1);
        step(1, 1, 8'd32);
        idle(1);
        pop_one();
        check("b2b_valid", 64'(rec_bus.rec_valid), 64'd1);
        check("b2b_len", 64'(rec_bus.rec_len), 64'd64);
        check("b2b_flits", 64'(rec_bus.rec_flits), 64'd2);
        check("b2b_pkts", 64'(total_pkts), 64'd3);
        check("b2b_bytes", 64'(total_bytes), 64'd134);
        pop_one();

        // five 1-flit packets into a 4-deep FIFO with consumer stalled
        for (int i = 1; i <= 5; i++) step(1, 1, 8'(i));
        idle(2);
        check("ovf_drop", 64'(drop_count), 64'd1);
        check("ovf_pkts", 64'(total_pkts), 64'd8);
        check("ovf_bytes", 64'(total_bytes), 64'd149);
        idle(3);
        check("ovf_hold_len", 64'(rec_bus.rec_len), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order", 64'(rec_bus.rec_len), 64'(i));
            pop_one();
        end
        check("ovf_empty", 64'(rec_bus.rec_valid), 64'd0);

        // 2100 flits of 32 bytes saturates the length but not the flit count
        for (int i = 0; i < 2100; i++) step(1, (i == 2099), 8'd32);
        idle(1);
        check("sat_len", 64'(rec_bus.rec_len), 64'hFFFF);
        check("sat_flits", 64'(rec_bus.rec_flits), 64'd2100);
        check("sat_flag", 64'(rec_bus.rec_sat), 64'd1);
        check("sat_bytes", 64'(total_bytes), 64'd65684);
        pop_one();
        step(1, 0, 8'd10);
        step(1, 1, 8'd10);
        idle(1);
        check("post_sat_len", 64'(rec_bus.rec_len), 64'd20);
        check("post_sat_flag", 64'(rec_bus.rec_sat), 64'd0);
        pop_one();

        // stats_clear coincident with a packet completion
        step(1, 1, 8'd9);
        stats_clear = 1'b1;
        idle(1);
        stats_clear = 1'b0;
        check("clr_pkts", 64'(total_pkts), 64'd0);
        check("clr_bytes", 64'(total_bytes), 64'd0);
        check("clr_drop", 64'(drop_count), 64'd0);
        check("clr_rec_valid", 64'(rec_bus.rec_valid), 64'd1);
        check("clr_rec_len", 64'(rec_bus.rec_len), 64'd9);
        pop_one();

        // full FIFO: push and pop in the same cycle
        for (int i = 11; i <= 14; i++) step(1, 1, 8'(i));
        idle(1);
        step(1, 1, 8'd15);
        rec_bus.rec_ready = 1'b1;
        idle(1);
        rec_bus.rec_ready = 1'b0;
        check("fullpp_drop", 64'(drop_count), 64'd0);
        check("fullpp_pkts", 64'(total_pkts), 64'd5);
        check("fullpp_bytes", 64'(total_bytes), 64'd65);
        for (int i = 12; i <= 15; i++) begin
            check("fullpp_order", 64'(rec_bus.rec_len), 64'(i));
            pop_one();
        end
        check("fullpp_empty", 64'(rec_bus.rec_valid), 64'd0);

        // reset mid-packet with a record queued
        step(1, 1, 8'd3);
        step(1, 0, 8'd32);
        step(1, 0, 8'd32);
        snoop_beat    = 1'b0;
        snoop_last    = 1'b0;
        bytes_in_flit = 8'd0;
        pend_bytes    = 8'd0;
        aresetn       = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(rec_bus.rec_valid), 64'd0);
        check("mid_rst_pkts", 64'(total_pkts), 64'd0);
        aresetn = 1'b1;
        idle(1);
        step(1, 1, 8'd7);
        idle(1);
        check("after_rst_valid", 64'(rec_bus.rec_valid), 64'd1);
        check("after_rst_len", 64'(rec_bus.rec_len), 64'd7);
        check("after_rst_flits", 64'(rec_bus.rec_flits), 64'd1);
        check("after_rst_pkts", 64'(total_pkts), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
